// File: rtl/ysyx_22040895_csr_pkg.sv
// Shared definitions for the machine-mode CSR file and trap sequencer:
// CSR addresses, request op codes, trap causes, mstatus bit positions, FSM states.
package ysyx_22040895_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;

    typedef enum logic [3:0] {
        NOP    = 4'd0,
        CSRRW  = 4'd1,
        CSRRS  = 4'd2,
        CSRRC  = 4'd3,
        CSRRWI = 4'd5,
        CSRRSI = 4'd6,
        CSRRCI = 4'd7,
        ECALL  = 4'd8,
        MRET   = 4'd9
    } csr_op_e;

    localparam int CAUSE_ECALL_M = 11;
    localparam int CAUSE_MTI     = 7;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LO   = 11;
    localparam int MSTATUS_MPP_HI   = 12;
    localparam int MIE_MTIE_BIT     = 7;
    localparam int MIP_MTIP_BIT     = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CSR_RESP,
        S_TRAP_SAVE,
        S_TRAP_JUMP,
        S_RET
    } state_e;

endpackage

// File: rtl/ysyx_22040895_csr_counter.sv
// Free-running XLEN-bit counter with a software write port; a write wins over the increment.
module ysyx_22040895_csr_counter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] value
);

    // Count register: write has priority, otherwise wrap-around increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (wr_en) begin
            value <= wdata;
        end else if (inc) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_22040895_csr_trap_unit.sv
// Machine-mode CSR file plus ecall/mret/timer-interrupt trap sequencer for the NPC core.
// One request per handshake; CSR responses and fetch redirects are registered pulses.
module ysyx_22040895_csr_trap_unit
    import ysyx_22040895_csr_pkg::*;
#(
    parameter int          XLEN         = 64,
    parameter logic [63:0] MSTATUS_RST  = 64'h0000_000a_0000_1800,
    parameter logic [63:0] MTVEC_RST    = 64'h0,
    parameter int          HAS_COUNTERS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [3:0]      op_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] src_i,
    input  logic            irq_timer_i,
    input  logic            instret_i,
    output logic            resp_valid_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            illegal_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o
);

    localparam logic [XLEN-1:0] MSTATUS_INIT = MSTATUS_RST[XLEN-1:0];
    localparam logic [XLEN-1:0] MTVEC_INIT   = MTVEC_RST[XLEN-1:0];
    localparam logic [XLEN-1:0] CAUSE_IRQ    = {1'b1, {(XLEN-4){1'b0}}, 3'd7};

    state_e state, state_next;

    logic [XLEN-1:0] mstatus, mtvec, mepc, mcause, mscratch, mie;
    logic [XLEN-1:0] mcycle, minstret;
    logic            mtip;

    logic            accept, irq_pend, take_trap, take_mret;
    logic            op_csr, op_wr, op_set, op_clr;
    logic [XLEN-1:0] rd_old, wval;
    logic            rd_legal, csr_we;

    logic [XLEN-1:0] trap_pc, trap_base, trap_target;
    logic            trap_irq;

    assign req_ready_o = (state == S_IDLE);
    assign accept      = req_valid_i & req_ready_o;
    assign irq_pend    = mstatus[MSTATUS_MIE_BIT] & mie[MIE_MTIE_BIT] & mtip;
    assign take_trap   = accept & (irq_pend | (op_i == ECALL));
    assign take_mret   = accept & ~irq_pend & (op_i == MRET);

    assign op_wr  = (op_i == CSRRW) | (op_i == CSRRWI);
    assign op_set = (op_i == CSRRS) | (op_i == CSRRSI);
    assign op_clr = (op_i == CSRRC) | (op_i == CSRRCI);
    assign op_csr = op_wr | op_set | op_clr;

    // Read mux: old value of the addressed CSR and whether the address exists.
    always_comb begin
        rd_old   = '0;
        rd_legal = 1'b1;
        case (csr_addr_i)
            CSR_MSTATUS:  rd_old = mstatus;
            CSR_MIE:      rd_old = mie;
            CSR_MTVEC:    rd_old = mtvec;
            CSR_MSCRATCH: rd_old = mscratch;
            CSR_MEPC:     rd_old = mepc;
            CSR_MCAUSE:   rd_old = mcause;
            CSR_MIP:      rd_old[MIP_MTIP_BIT] = mtip;
            CSR_MCYCLE:   rd_old = mcycle;
            CSR_MINSTRET: rd_old = minstret;
            default:      rd_legal = 1'b0;
        endcase
    end

    // Set/clear with a zero mask leaves the CSR untouched; an interrupt suppresses the op.
    assign wval   = op_wr ? src_i : (op_set ? (rd_old | src_i) : (rd_old & ~src_i));
    assign csr_we = accept & ~irq_pend & op_csr & rd_legal & (op_wr | (src_i != '0));

    assign trap_base   = {mtvec[XLEN-1:2], 2'b00};
    assign trap_target = ((mtvec[1:0] == 2'b01) && trap_irq) ? trap_base + XLEN'(28) : trap_base;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // FSM next state: interrupts and ecall trap, mret returns, everything else responds.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (take_trap)      state_next = S_TRAP_SAVE;
                else if (take_mret) state_next = S_RET;
                else if (accept)    state_next = S_CSR_RESP;
            end
            S_TRAP_SAVE: state_next = S_TRAP_JUMP;
            default:     state_next = S_IDLE;
        endcase
    end

    // Trap context captured at accept and consumed in TRAP_SAVE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_pc  <= '0;
            trap_irq <= 1'b0;
        end else if (take_trap) begin
            trap_pc  <= pc_i;
            trap_irq <= irq_pend;
        end
    end

    // CSR registers: software writes, trap entry save, mret restore.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus  <= MSTATUS_INIT;
            mtvec    <= MTVEC_INIT;
            mepc     <= '0;
            mcause   <= '0;
            mscratch <= '0;
            mie      <= '0;
            mtip     <= 1'b0;
        end else begin
            mtip <= irq_timer_i;
            if (csr_we) begin
                case (csr_addr_i)
                    CSR_MSTATUS:  mstatus  <= wval;
                    CSR_MIE:      mie      <= wval;
                    CSR_MTVEC:    mtvec    <= wval;
                    CSR_MSCRATCH: mscratch <= wval;
                    CSR_MEPC:     mepc     <= {wval[XLEN-1:2], 2'b00};
                    CSR_MCAUSE:   mcause   <= wval;
                    default: ;
                endcase
            end
            if (state == S_TRAP_SAVE) begin
                mepc   <= trap_pc;
                mcause <= trap_irq ? CAUSE_IRQ : XLEN'(CAUSE_ECALL_M);
                mstatus[MSTATUS_MPIE_BIT] <= mstatus[MSTATUS_MIE_BIT];
                mstatus[MSTATUS_MIE_BIT]  <= 1'b0;
                mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
            end
            if (take_mret) begin
                mstatus[MSTATUS_MIE_BIT]  <= mstatus[MSTATUS_MPIE_BIT];
                mstatus[MSTATUS_MPIE_BIT] <= 1'b1;
                mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b00;
            end
        end
    end

    // Registered response and redirect outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_o     <= 1'b0;
            rdata_o          <= '0;
            illegal_o        <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else begin
            resp_valid_o     <= accept & ~take_trap & ~take_mret;
            illegal_o        <= accept & ~take_trap & op_csr & ~rd_legal;
            redirect_valid_o <= (state == S_TRAP_SAVE) | take_mret;
            if (accept && !take_trap && !take_mret)
                rdata_o <= (op_csr && rd_legal) ? rd_old : '0;
            if (state == S_TRAP_SAVE)
                redirect_pc_o <= trap_target;
            else if (take_mret)
                redirect_pc_o <= mepc;
        end
    end

    if (HAS_COUNTERS != 0) begin : g_counters
        ysyx_22040895_csr_counter #(.XLEN(XLEN)) u_mcycle (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (1'b1),
            .wr_en (csr_we && (csr_addr_i == CSR_MCYCLE)),
            .wdata (wval),
            .value (mcycle)
        );
        ysyx_22040895_csr_counter #(.XLEN(XLEN)) u_minstret (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (instret_i),
            .wr_en (csr_we && (csr_addr_i == CSR_MINSTRET)),
            .wdata (wval),
            .value (minstret)
        );
    end else begin : g_no_counters
        assign mcycle   = '0;
        assign minstret = '0;
    end

endmodule

// File: tb/tb_ysyx_22040895_csr_trap_unit.sv
// Directed bench for the CSR/trap unit: a vector table of CSR ops plus
// hand-written trap, return, interrupt, counter-wrap and reset-abort sequences.
module tb_ysyx_22040895_csr_trap_unit;
    import ysyx_22040895_csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  op;
    logic [11:0] csr_addr;
    logic [63:0] pc;
    logic [63:0] src;
    logic        irq_timer;
    logic        instret;
    logic        resp_valid;
    logic [63:0] rdata;
    logic        illegal;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_22040895_csr_trap_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .op_i             (op),
        .csr_addr_i       (csr_addr),
        .pc_i             (pc),
        .src_i            (src),
        .irq_timer_i      (irq_timer),
        .instret_i        (instret),
        .resp_valid_o     (resp_valid),
        .rdata_o          (rdata),
        .illegal_o        (illegal),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc)
    );

    typedef struct {
        logic [3:0]  op;
        logic [11:0] addr;
        logic [63:0] src;
        logic [63:0] exp_rdata;
        logic        exp_ill;
    } vec_t;

    vec_t vecs [0:18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; waits (bounded) for ready, then holds the request across one rising edge.
    task automatic issue(input logic [3:0] o, input logic [11:0] a, input logic [63:0] s, input logic [63:0] p);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("ready_timeout", {63'b0, req_ready}, 64'd1);
        req_valid = 1'b1;
        op        = o;
        csr_addr  = a;
        src       = s;
        pc        = p;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic csr(input logic [3:0] o, input logic [11:0] a, input logic [63:0] s,
                       output logic [63:0] rd, output logic ill);
        issue(o, a, s, 64'h0);
        @(negedge clk);
        check("resp_valid", {63'b0, resp_valid}, 64'd1);
        rd  = rdata;
        ill = illegal;
    endtask

    task automatic read_csr(input string name, input logic [11:0] a, input logic [63:0] exp);
        logic [63:0] rd;
        logic        ill;
        csr(CSRRS, a, 64'h0, rd, ill);
        check(name, rd, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd, c0, c1;
        logic        ill;

        vecs[0]  = '{CSRRS,  CSR_MSTATUS,  64'h0,                 64'h0000000a00001800, 1'b0};
        vecs[1]  = '{CSRRCI, CSR_MSTATUS,  64'h0,                 64'h0000000a00001800, 1'b0};
        vecs[2]  = '{CSRRW,  CSR_MTVEC,    64'h80000100,          64'h0,                1'b0};
        vecs[3]  = '{CSRRS,  CSR_MTVEC,    64'h0,                 64'h80000100,         1'b0};
        vecs[4]  = '{CSRRS,  12'h7FF,      64'h5,                 64'h0,                1'b1};
        vecs[5]  = '{CSRRS,  CSR_MTVEC,    64'h0,                 64'h80000100,         1'b0};
        vecs[6]  = '{CSRRW,  CSR_MSCRATCH, 64'h123456789abcdef0,  64'h0,                1'b0};
        vecs[7]  = '{CSRRSI, CSR_MSCRATCH, 64'hf,                 64'h123456789abcdef0, 1'b0};
        vecs[8]  = '{CSRRC,  CSR_MSCRATCH, 64'hff00,              64'h123456789abcdeff, 1'b0};
        vecs[9]  = '{CSRRS,  CSR_MSCRATCH, 64'h0,                 64'h123456789abc00ff, 1'b0};
        vecs[10] = '{CSRRW,  CSR_MEPC,     64'h80000043,          64'h0,                1'b0};
        vecs[11] = '{CSRRS,  CSR_MEPC,     64'h0,                 64'h80000040,         1'b0};
        vecs[12] = '{CSRRS,  CSR_MIP,      64'h0,                 64'h0,                1'b0};
        vecs[13] = '{CSRRW,  CSR_MIE,      64'h80,                64'h0,                1'b0};
        vecs[14] = '{CSRRC,  CSR_MIE,      64'h80,                64'h80,               1'b0};
        vecs[15] = '{CSRRS,  CSR_MIE,      64'h0,                 64'h0,                1'b0};
        vecs[16] = '{CSRRWI, CSR_MINSTRET, 64'h5,                 64'h0,                1'b0};
        vecs[17] = '{CSRRS,  CSR_MINSTRET, 64'h0,                 64'h5,                1'b0};
        vecs[18] = '{CSRRSI, CSR_MSTATUS,  64'h8,                 64'h0000000a00001800, 1'b0};

        rst_n = 1'b0; req_valid = 1'b0; op = 4'd0; csr_addr = 12'h0;
        pc = 64'h0; src = 64'h0; irq_timer = 1'b0; instret = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {63'b0, req_ready}, 64'd1);
        check("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
        check("rst_redirect_valid", {63'b0, redirect_valid}, 64'd0);
        check("rst_illegal", {63'b0, illegal}, 64'd0);
        check("rst_rdata", rdata, 64'h0);
        check("rst_redirect_pc", redirect_pc, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i <= 18; i++) begin
            csr(vecs[i].op, vecs[i].addr, vecs[i].src, rd, ill);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_illegal", i), {63'b0, ill}, {63'b0, vecs[i].exp_ill});
        end

        // minstret counts retired instructions: three cycles of instret.
        instret = 1'b1;
        repeat (3) @(negedge clk);
        instret = 1'b0;
        read_csr("minstret_count", CSR_MINSTRET, 64'h8);

        // mcycle advances by two between back-to-back reads.
        csr(CSRRS, CSR_MCYCLE, 64'h0, c0, ill);
        csr(CSRRS, CSR_MCYCLE, 64'h0, c1, ill);
        check("mcycle_delta", c1 - c0, 64'd2);

        // ecall: two-cycle trap entry, redirect to mtvec base.
        issue(ECALL, 12'h0, 64'h0, 64'h80000040);
        @(negedge clk);
        check("ecall_save_no_redirect", {63'b0, redirect_valid}, 64'd0);
        check("ecall_save_busy", {63'b0, req_ready}, 64'd0);
        @(negedge clk);
        check("ecall_redirect_valid", {63'b0, redirect_valid}, 64'd1);
        check("ecall_redirect_pc", redirect_pc, 64'h80000100);
        @(negedge clk);
        check("ecall_redirect_pulse", {63'b0, redirect_valid}, 64'd0);
        read_csr("ecall_mepc", CSR_MEPC, 64'h80000040);
        read_csr("ecall_mcause", CSR_MCAUSE, 64'd11);
        read_csr("ecall_mstatus", CSR_MSTATUS, 64'h0000000a00001880);

        // mret: one-cycle return to mepc.
        issue(MRET, 12'h0, 64'h0, 64'h0);
        @(negedge clk);
        check("mret_redirect_valid", {63'b0, redirect_valid}, 64'd1);
        check("mret_redirect_pc", redirect_pc, 64'h80000040);
        @(negedge clk);
        check("mret_redirect_pulse", {63'b0, redirect_valid}, 64'd0);
        read_csr("mret_mstatus", CSR_MSTATUS, 64'h0000000a00000088);

        // Timer interrupt overrides a CSRRW; vectored mtvec.
        csr(CSRRW, CSR_MTVEC, 64'h80000101, rd, ill);
        check("mtvec_old", rd, 64'h80000100);
        csr(CSRRW, CSR_MIE, 64'h80, rd, ill);
        irq_timer = 1'b1;
        @(negedge clk);
        issue(CSRRW, CSR_MSCRATCH, 64'hdead, 64'h80000200);
        @(negedge clk);
        check("irq_no_resp", {63'b0, resp_valid}, 64'd0);
        @(negedge clk);
        check("irq_redirect_valid", {63'b0, redirect_valid}, 64'd1);
        check("irq_redirect_pc", redirect_pc, 64'h8000011C);
        @(negedge clk);
        read_csr("irq_mip_set", CSR_MIP, 64'h80);
        irq_timer = 1'b0;
        @(negedge clk);
        read_csr("irq_mip_clear", CSR_MIP, 64'h0);
        read_csr("irq_mcause", CSR_MCAUSE, 64'h8000000000000007);
        read_csr("irq_mepc", CSR_MEPC, 64'h80000200);
        read_csr("irq_mscratch_kept", CSR_MSCRATCH, 64'h123456789abc00ff);

        // mcycle wraps from all-ones to zero.
        csr(CSRRW, CSR_MCYCLE, 64'hffffffffffffffff, rd, ill);
        read_csr("mcycle_wrap", CSR_MCYCLE, 64'h0);

        // Reset during TRAP_SAVE aborts the trap.
        issue(ECALL, 12'h0, 64'h0, 64'h80000300);
        rst_n = 1'b0;
        #1;
        check("abort_ready", {63'b0, req_ready}, 64'd1);
        check("abort_redirect", {63'b0, redirect_valid}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("abort_hold%0d_redirect", i), {63'b0, redirect_valid}, 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_idle", {63'b0, req_ready}, 64'd1);
        read_csr("abort_mepc", CSR_MEPC, 64'h0);
        read_csr("abort_mcause", CSR_MCAUSE, 64'h0);
        read_csr("abort_mstatus", CSR_MSTATUS, 64'h0000000a00001800);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
